// File: rtl/seq_pkg.sv
// Shared encodings for the ALU instruction sequencer: state codes, IR field
// positions and default opcode constants.
package seq_pkg;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;
    localparam logic [2:0] S_T5   = 3'd6;
    localparam logic [2:0] S_HALT = 3'd7;

    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

    localparam logic [4:0] DEF_INC_PC_OP  = 5'd12;
    localparam logic [4:0] DEF_HALT_OP    = 5'd31;
    localparam logic [4:0] DEF_MAX_ALU_OP = 5'd11;
endpackage

// File: rtl/reg_select_decoder.sv
// 4-bit register index to 16-bit one-hot select; all zero when disabled.
module reg_select_decoder (
    input  logic [3:0]  idx_i,
    input  logic        en_i,
    output logic [15:0] onehot_o
);
    always_comb begin
        onehot_o = '0;
        if (en_i) onehot_o[idx_i] = 1'b1;
    end
endmodule

// File: rtl/alu_instr_sequencer.sv
// Control unit sequencing the Datapath through fetch (T0-T2) and a
// three-register ALU execute (T3-T5). Strobes decode from state and IR.
module alu_instr_sequencer
    import seq_pkg::*;
#(
    parameter logic [4:0] INC_PC_OP  = DEF_INC_PC_OP,
    parameter logic [4:0] HALT_OP    = DEF_HALT_OP,
    parameter logic [4:0] MAX_ALU_OP = DEF_MAX_ALU_OP
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        stop,
    input  logic        mem_rdy,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Read,
    output logic [4:0]  OpCode,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        instr_done,
    output logic        illegal_op,
    output logic        halted,
    output logic [15:0] instr_count
);
    logic [2:0]  state_q, state_d;
    logic        first_q;
    logic [15:0] count_q;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_halt;
    logic       unused_ir;

    assign op        = ir[OP_HI:OP_LO];
    assign ra        = ir[RA_HI:RA_LO];
    assign rb        = ir[RB_HI:RB_LO];
    assign rc        = ir[RC_HI:RC_LO];
    assign is_alu    = (op <= MAX_ALU_OP);
    assign is_halt   = (op == HALT_OP);
    assign unused_ir = ^ir[RC_LO-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: if (start) state_d = S_T0;
            S_T0:           state_d = S_T1;
            S_T1:           if (mem_rdy) state_d = S_T2;
            S_T2:           state_d = S_T3;
            S_T3: begin
                if (is_alu)       state_d = S_T4;
                else if (is_halt) state_d = S_HALT;
                else              state_d = stop ? S_IDLE : S_T0;
            end
            S_T4:           state_d = S_T5;
            S_T5:           state_d = stop ? S_IDLE : S_T0;
            default:        state_d = S_IDLE;
        endcase
    end

    // first_q marks the first T1 cycle so the PC is loaded only once per fetch
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_IDLE;
            first_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            first_q <= (state_q == S_T0);
            if (state_q == S_T5) count_q <= count_q + 16'd1;
        end
    end

    always_comb begin
        PCout      = (state_q == S_T0);
        MARin      = (state_q == S_T0);
        Zin        = (state_q == S_T0) || (state_q == S_T4);
        PCin       = (state_q == S_T1) && first_q;
        Zlowout    = ((state_q == S_T1) && first_q) || (state_q == S_T5);
        Read       = (state_q == S_T1);
        MDRin      = (state_q == S_T1);
        MDRout     = (state_q == S_T2);
        IRin       = (state_q == S_T2);
        Yin        = (state_q == S_T3) && is_alu;
        illegal_op = (state_q == S_T3) && !is_alu && !is_halt;
        instr_done = (state_q == S_T5);
        halted     = (state_q == S_HALT);
        OpCode     = '0;
        if (state_q == S_T0)      OpCode = INC_PC_OP;
        else if (state_q == S_T4) OpCode = op;
    end

    reg_select_decoder u_rin_dec (
        .idx_i    (ra),
        .en_i     (state_q == S_T5),
        .onehot_o (Rin)
    );

    reg_select_decoder u_rout_dec (
        .idx_i    ((state_q == S_T3) ? rb : rc),
        .en_i     (((state_q == S_T3) && is_alu) || (state_q == S_T4)),
        .onehot_o (Rout)
    );

    assign instr_count = count_q;
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed + randomized bench for alu_instr_sequencer; expected strobes are
// built per instruction phase from the instruction-level rules.
module tb_alu_instr_sequencer;
    logic        clk = 1'b0;
    logic        clr, start, stop, mem_rdy;
    logic [31:0] ir;
    logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, Read;
    logic [4:0]  OpCode;
    logic [15:0] Rin, Rout, instr_count;
    logic        instr_done, illegal_op, halted;

    typedef struct packed {
        logic        pcout, zlowout, mdrout, marin, zin, pcin, mdrin, irin, yin, read;
        logic [4:0]  opcode;
        logic [15:0] rin, rout;
        logic        done, ill, hlt;
    } strb_t;

    strb_t       obs;
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] model_cnt = '0;

    assign obs = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, Read,
                  OpCode, Rin, Rout, instr_done, illegal_op, halted};

    always #5 clk = ~clk;

    alu_instr_sequencer dut (
        .clk(clk), .clr(clr), .start(start), .stop(stop), .mem_rdy(mem_rdy), .ir(ir),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
        .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Read(Read),
        .OpCode(OpCode), .Rin(Rin), .Rout(Rout), .instr_done(instr_done),
        .illegal_op(illegal_op), .halted(halted), .instr_count(instr_count)
    );

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic chk_at(input string tag, input strb_t e);
        @(negedge clk);
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic chk_cnt(input string tag);
        n_assert++;
        assert (instr_count === model_cnt) else begin
            n_fail++;
            $error("FAIL %s instr_count observed=%0d expected=%0d", tag, instr_count, model_cnt);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        nxt();
        start = 1'b0;
    endtask

    // Entered just after the edge into T0; returns just after the edge leaving
    // the instruction. Every phase is one check, so latency errors show up.
    task automatic run_instr(input logic [31:0] irv, input int waits,
                             input bit stop_t4, input bit stop_end);
        strb_t e;
        logic [4:0] op;
        logic [15:0] one = 16'h1;
        op = irv[31:27];
        ir = irv; stop = 1'b0; start = 1'b0; mem_rdy = 1'($urandom);
        e = '0; e.pcout = 1; e.marin = 1; e.zin = 1; e.opcode = 5'd12;
        chk_at("T0", e);
        for (int w = 0; w <= waits; w++) begin
            nxt();
            mem_rdy = (w == waits);
            e = '0; e.read = 1; e.mdrin = 1;
            if (w == 0) begin e.pcin = 1; e.zlowout = 1; end
            chk_at("T1", e);
        end
        nxt();
        mem_rdy = 1'($urandom); start = 1'($urandom);
        e = '0; e.mdrout = 1; e.irin = 1;
        chk_at("T2", e);
        nxt();
        start = 1'b0;
        e = '0;
        if (op <= 5'd11) begin
            e.rout = one << irv[22:19]; e.yin = 1;
        end else if (op != 5'd31) begin
            e.ill = 1; stop = stop_end;
        end
        chk_at("T3", e);
        if (op <= 5'd11) begin
            nxt();
            stop = stop_t4; start = 1'($urandom);
            e = '0; e.rout = one << irv[18:15]; e.opcode = op; e.zin = 1;
            chk_at("T4", e);
            nxt();
            stop = stop_end; start = 1'b0;
            e = '0; e.zlowout = 1; e.rin = one << irv[26:23]; e.done = 1;
            chk_at("T5", e);
            model_cnt = model_cnt + 16'd1;
        end
        nxt();
        stop = 1'b0;
        chk_cnt("count");
        if (op == 5'd31) begin
            e = '0; e.hlt = 1; chk_at("HALT", e);
        end else if (stop_end) begin
            e = '0; chk_at("IDLE", e);
        end
    endtask

    initial begin
        strb_t z;
        logic [31:0] r;
        logic [4:0] op;
        int kind;
        bit se;
        z = '0;
        clr = 1'b0; start = 1'b1; stop = 1'b0; mem_rdy = 1'b1; ir = '0;
        repeat (2) nxt();
        clr = 1'b1; start = 1'b0;
        chk_at("reset", z);
        chk_cnt("reset_count");
        nxt();
        chk_at("idle", z);

        do_start();
        run_instr(32'h28918000, 0, 1'b0, 1'b0);
        run_instr(32'h28918000, 3, 1'b0, 1'b0);
        run_instr({5'd31, 27'h0}, 0, 1'b0, 1'b0);
        do_start();
        run_instr({5'd20, 4'd1, 4'd2, 4'd3, 15'h0}, 1, 1'b0, 1'b0);
        run_instr({5'd11, 4'd0, 4'd15, 4'd0, 15'h7fff}, 0, 1'b1, 1'b1);
        do_start();
        run_instr({5'd0, 4'd7, 4'd7, 4'd7, 15'h0}, 2, 1'b1, 1'b0);
        run_instr({5'd12, 4'd7, 4'd7, 4'd7, 15'h0}, 0, 1'b0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 7)      op = 5'($urandom_range(0, 11));
            else if (kind < 9) op = 5'($urandom_range(12, 30));
            else               op = 5'd31;
            r = {op, 27'($urandom)};
            se = ($urandom_range(0, 3) == 0);
            do_start();
            run_instr(r, $urandom_range(0, 3), 1'($urandom), se);
            while (!se && op != 5'd31) begin
                kind = $urandom_range(0, 9);
                op = (kind < 8) ? 5'($urandom_range(0, 11)) : 5'($urandom_range(12, 31));
                r = {op, 27'($urandom)};
                se = ($urandom_range(0, 2) == 0);
                run_instr(r, $urandom_range(0, 3), 1'($urandom), se);
            end
        end

        do_start();
        nxt();
        clr = 1'b0; start = 1'b1;
        nxt();
        clr = 1'b1; start = 1'b0;
        model_cnt = '0;
        chk_at("midop_reset", z);
        chk_cnt("midop_reset_count");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
- Control unit that sequences the Datapath through fetch (T0–T2) and three-register ALU execute (T3–T5).
- Drives every Datapath strobe (PCout, MARin, Zin, Read, MDRin, IRin, Yin, Zlowout, register in/out selects, ALU OpCode) from its own state register and the IR contents.
- Replaces hand-scripted control sequences in benches and is the first piece of the CPU control path.

Parameters:
- INC_PC_OP, 5'd12, ALU OpCode driven in T0 for the PC increment.
- HALT_OP, 5'd31, IR opcode that stops the sequencer.
- MAX_ALU_OP, 5'd11, highest IR opcode treated as a three-register ALU instruction. Opcodes 0..MAX_ALU_OP are legal.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- clr  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; leaves IDLE or HALT.
- stop  in  1  level; finish the current instruction, then go to IDLE.
- mem_rdy  in  1  memory read complete; sampled in T1.
- ir  in  32  Datapath IR contents: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, Read  out  1 each  Datapath strobes.
- OpCode  out  5  ALU control.
- Rin  out  16  one-hot register load enables (R0..R15).
- Rout  out  16  one-hot register drive enables (R0..R15).
- instr_done  out  1  one-cycle pulse in T5.
- illegal_op  out  1  one-cycle pulse on an undecodable opcode.
- halted  out  1  high while in HALT.
- instr_count  out  16  retired-instruction counter.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT. Held in a registered state variable.
- Strobe outputs are decoded combinationally from the state and ir. Every strobe is 0 in IDLE and HALT.
- Reset: clr sampled low → state IDLE, instr_count = 0, halted = 0. All outputs read 0 in the following cycle. Reset applies from any state, including mid-fetch, and overrides start on the same edge.
- IDLE → T0 on start. HALT → T0 on start.
- T0: PCout=1, MARin=1, OpCode=INC_PC_OP, Zin=1. Next state T1.
- T1: Zlowout=1, PCin=1, Read=1, MDRin=1.
  - Stay in T1 while mem_rdy=0.
  - Read and MDRin are held for the whole wait.
  - PCin and Zlowout are asserted only in the first T1 cycle (first-cycle flag register), so PC increments exactly once.
  - → T2 on mem_rdy=1.
- T2: MDRout=1, IRin=1. → T3.
- T3: decode ir[31:27].
  - Legal ALU op: Rout[Rb]=1, Yin=1. → T4.
  - opcode == HALT_OP: no strobes. → HALT. halted=1 from the next cycle.
  - Any other opcode: illegal_op=1 for this cycle, no strobes. → T0, or IDLE if stop=1.
- T4: Rout[Rc]=1, OpCode=ir[31:27], Zin=1. → T5.
- T5: Zlowout=1, Rin[Ra]=1, instr_done=1. instr_count increments by 1 (wraps 16'hFFFF → 0). → T0, or IDLE if stop=1 this cycle.
- Ra may equal Rb or Rc, and R0 is writable. Rin/Rout are exactly one-hot when active and all-zero otherwise.
- start outside IDLE/HALT is ignored. stop sampled in any state other than T3/T5 has no effect until the next T3 or T5 decision point.
- Latency: 6 cycles per instruction T0→T5 when mem_rdy is high in the first T1 cycle. Add one cycle per T1 wait cycle.
- ir is sampled only in T3–T5; its value in other states is don't-care.

Decomposition:
- Shared package seq_pkg:
  - state encoding (localparams, 3-bit, IDLE=0).
  - IR field bit positions.
  - opcode constants (HALT_OP, INC_PC_OP, MAX_ALU_OP defaults).
- Sub-module reg_select_decoder: 4-bit index plus enable → 16-bit one-hot. Instantiated twice (Rin, Rout).

Test Plan:
- Reset/start: clr=0 for 2 cycles, then clr=1, start pulse → all strobes 0 in IDLE; T0 the cycle after start with PCout=MARin=Zin=1 and OpCode=12.
- Fetch/execute: ir=32'h28918000 (opcode 5, Ra=1, Rb=2, Rc=3), mem_rdy tied 1:
  - T3: Rout=16'h0004, Yin=1.
  - T4: Rout=16'h0008, OpCode=5.
  - T5: Rin=16'h0002, Zlowout=1, instr_done=1.
  - instr_count=1; 6 cycles total.
- Memory wait: mem_rdy low for 3 cycles in T1 → Read/MDRin high for 4 cycles, PCin high only in the first; total 9 cycles.
- Halt and illegal:
  - ir opcode 31 → HALT, halted=1, strobes 0; start → T0, halted=0.
  - ir opcode 20 → illegal_op pulse in T3, next state T0, instr_count unchanged.
- Stop and reset mid-op:
  - stop=1 during T4 → after T5, IDLE.
  - clr=0 in T1 with start=1 → IDLE next cycle, all outputs 0, instr_count=0.
